// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a row-major feature map using a half-width line buffer.
// Optional build macro POOL_RELU_EN fuses a ReLU clamp on every input sample.
module maxpool2x2_stream #(
  parameter int DATA_W   = 16,
  parameter int MAX_COLS = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [4:0]               featmap_size,
  input  logic                     din_valid,
  input  logic signed [DATA_W-1:0] din,
  output logic                     dout_valid,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_last,
  output logic                     map_done,
  output logic                     size_err
);

  localparam int LB_DEPTH = MAX_COLS / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [4:0] MAXN = 5'(MAX_COLS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state_q;
  logic [4:0]                 n_q, row_q, col_q;
  logic signed [DATA_W-1:0]   h_q, dout_q;
  logic                       dout_valid_q, dout_last_q, map_done_q, size_err_q;
  logic signed [DATA_W-1:0]   linebuf [LB_DEPTH];

  logic signed [DATA_W-1:0]   sample, lb_rd;
  logic [LB_AW-1:0]           lb_idx;
  logic [4:0]                 last_pair, n_m1;
  logic                       size_ok, lb_we;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DATA_W-1:0] relu_in(input logic signed [DATA_W-1:0] x);
`ifdef POOL_RELU_EN
    return (x < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  assign sample    = relu_in(din);
  assign lb_idx    = LB_AW'(col_q >> 1);
  assign lb_rd     = linebuf[lb_idx];
  assign size_ok   = (featmap_size >= 5'd2) && (featmap_size <= MAXN);
  assign n_m1      = n_q - 5'd1;
  // Last emitting row/col is the odd index closing the final full 2x2 window.
  assign last_pair = {n_q[4:1], 1'b0} - 5'd1;
  assign lb_we     = (state_q == RUN) && din_valid && !clear && !row_q[0] && col_q[0];

  // Even rows fold column pairs into the line buffer; odd rows read them back.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf[lb_idx] <= smax(h_q, sample);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      h_q          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      map_done_q   <= 1'b0;
      size_err_q   <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      map_done_q   <= dout_last_q;
      if (clear) begin
        state_q <= IDLE;
        row_q   <= '0;
        col_q   <= '0;
      end else if (din_valid) begin
        if (state_q == IDLE) begin
          n_q        <= featmap_size;
          size_err_q <= !size_ok;
          if (size_ok) begin
            h_q     <= sample;
            row_q   <= '0;
            col_q   <= 5'd1;
            state_q <= RUN;
          end
        end else begin
          if (!col_q[0]) begin
            h_q <= sample;
          end else if (row_q[0]) begin
            dout_q       <= smax(smax(lb_rd, h_q), sample);
            dout_valid_q <= 1'b1;
            dout_last_q  <= (row_q == last_pair) && (col_q == last_pair);
          end
          if (col_q == n_m1) begin
            col_q <= '0;
            if (row_q == n_m1) begin
              row_q   <= '0;
              state_q <= IDLE;
            end else begin
              row_q <= row_q + 5'd1;
            end
          end else begin
            col_q <= col_q + 5'd1;
          end
        end
      end
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign dout_last  = dout_last_q;
  assign map_done   = map_done_q;
  assign size_err   = size_err_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: hand-computed pooled values, latencies and control strobes.
module tb_maxpool2x2_stream;

  localparam int DATA_W = 16;

  logic                     clk = 1'b0;
  logic                     rst_n, clear, din_valid;
  logic [4:0]               featmap_size;
  logic signed [DATA_W-1:0] din, dout;
  logic                     dout_valid, dout_last, map_done, size_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int oq[$];
  int lq[$];
  int cq[$];
  int mq[$];

  maxpool2x2_stream #(.DATA_W(DATA_W), .MAX_COLS(28)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .featmap_size(featmap_size),
    .din_valid(din_valid), .din(din), .dout_valid(dout_valid), .dout(dout),
    .dout_last(dout_last), .map_done(map_done), .size_err(size_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_valid) begin
      oq.push_back(int'(dout));
      lq.push_back(int'(dout_last));
      cq.push_back(cyc);
    end
    if (map_done) mq.push_back(cyc);
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input int n, input int v, input bit vld, input bit clr, output int bc);
    @(negedge clk);
    featmap_size = 5'(n);
    din          = DATA_W'(v);
    din_valid    = vld;
    clear        = clr;
    bc           = cyc;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      din_valid = 1'b0;
      clear     = 1'b0;
    end
  endtask

  task automatic flush();
    oq.delete(); lq.delete(); cq.delete(); mq.delete();
  endtask

  task automatic map2(input int a, input int b, input int c, input int d);
    int bc;
    beat(2, a, 1, 0, bc);
    beat(2, b, 1, 0, bc);
    beat(2, c, 1, 0, bc);
    beat(2, d, 1, 0, bc);
  endtask

  initial begin
    int bc, t0;
    int bcs[16];
    int exp_neg;

    rst_n = 1'b0; clear = 1'b0; din_valid = 1'b0; din = '0; featmap_size = '0;
    repeat (3) @(negedge clk);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_last", dout_last, 0);
    check("rst_map_done", map_done, 0);
    check("rst_size_err", size_err, 0);
    rst_n = 1'b1;
    idle(2);
    flush();

    // N=4 ramp, size presented only on the first beat
    t0 = 0;
    for (int i = 0; i < 16; i++) begin
      beat((i == 0) ? 4 : 0, i, 1, 0, bc);
      if (i == 0) t0 = bc;
    end
    idle(4);
    check("ramp_count", oq.size(), 4);
    if (oq.size() == 4) begin
      check("ramp_v0", oq[0], 5);
      check("ramp_v1", oq[1], 7);
      check("ramp_v2", oq[2], 13);
      check("ramp_v3", oq[3], 15);
      check("ramp_t0", cq[0] - t0, 6);
      check("ramp_t1", cq[1] - t0, 8);
      check("ramp_t2", cq[2] - t0, 14);
      check("ramp_t3", cq[3] - t0, 16);
      check("ramp_last_early", lq[0] | lq[1] | lq[2], 0);
      check("ramp_last", lq[3], 1);
      check("ramp_done_count", mq.size(), 1);
      if (mq.size() == 1) check("ramp_done_t", mq[0] - cq[3], 1);
    end
    check("ramp_size_err", size_err, 0);
    flush();

    // N=4 all -3
`ifdef POOL_RELU_EN
    exp_neg = 0;
`else
    exp_neg = -3;
`endif
    for (int i = 0; i < 16; i++) beat(4, -3, 1, 0, bc);
    idle(4);
    check("neg_count", oq.size(), 4);
    for (int i = 0; i < oq.size(); i++) check("neg_val", oq[i], exp_neg);
    flush();

    // Signed comparisons on N=2 maps
    map2(-5, 3, -100, -1);
    map2(-5, -2, -100, -7);
    idle(4);
    check("sgn_count", oq.size(), 2);
    if (oq.size() == 2) begin
      check("sgn_mixed", oq[0], 3);
`ifdef POOL_RELU_EN
      check("sgn_allneg", oq[1], 0);
`else
      check("sgn_allneg", oq[1], -2);
`endif
      check("sgn_lasts", lq[0] + lq[1], 2);
    end
    flush();

    // N=5 ramp, then back-to-back N=2 map proves the map ends after beat 25
    for (int i = 0; i < 25; i++) beat(5, i, 1, 0, bc);
    map2(10, 20, 30, 40);
    idle(4);
    check("odd_count", oq.size(), 5);
    if (oq.size() == 5) begin
      check("odd_v0", oq[0], 6);
      check("odd_v1", oq[1], 8);
      check("odd_v2", oq[2], 16);
      check("odd_v3", oq[3], 18);
      check("odd_last_early", lq[0] | lq[1] | lq[2], 0);
      check("odd_last", lq[3], 1);
      check("odd_next_map", oq[4], 40);
      check("odd_next_last", lq[4], 1);
    end
    check("odd_done_count", mq.size(), 2);
    flush();

    // N=4 ramp with a gap after every beat
    for (int i = 0; i < 16; i++) begin
      beat(4, i, 1, 0, bcs[i]);
      beat(0, 99, 0, 0, bc);
    end
    idle(4);
    check("gap_count", oq.size(), 4);
    if (oq.size() == 4) begin
      check("gap_v0", oq[0], 5);
      check("gap_v3", oq[3], 15);
      check("gap_t0", cq[0] - bcs[5], 1);
      check("gap_t1", cq[1] - bcs[7], 1);
      check("gap_t2", cq[2] - bcs[13], 1);
      check("gap_t3", cq[3] - bcs[15], 1);
      check("gap_last", lq[3], 1);
    end
    flush();

    // N=28 ramp followed immediately by N=2 map
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) beat(28, r * 28 + c, 1, 0, bc);
    map2(1, 9, 4, 2);
    idle(4);
    check("big_count", oq.size(), 197);
    if (oq.size() == 197) begin
      for (int k = 0; k < 196; k++)
        check("big_val", oq[k], (2 * (k / 14) + 1) * 28 + 2 * (k % 14) + 1);
      check("big_last", lq[195], 1);
      check("big_last_early", lq[194], 0);
      check("big_next_val", oq[196], 9);
      check("big_next_last", lq[196], 1);
    end
    check("big_done_count", mq.size(), 2);
    flush();

    // Illegal sizes: beats dropped, size_err raised
    for (int i = 0; i < 4; i++) beat(1, i + 50, 1, 0, bc);
    idle(3);
    check("size1_err", size_err, 1);
    check("size1_no_out", oq.size(), 0);
    for (int i = 0; i < 4; i++) beat(29, i + 50, 1, 0, bc);
    idle(3);
    check("size29_err", size_err, 1);
    check("size29_no_out", oq.size(), 0);
    flush();

    // Clear lands on the window-completing beat of an N=4 map
    for (int i = 0; i < 5; i++) beat(4, i + 100, 1, 0, bc);
    idle(1);
    check("clr_size_err", size_err, 0);
    beat(4, 200, 1, 1, bc);
    idle(3);
    check("clr_no_out", oq.size(), 0);
    map2(1, 9, 4, 2);
    idle(4);
    check("clr_next_count", oq.size(), 1);
    if (oq.size() == 1) begin
      check("clr_next_val", oq[0], 9);
      check("clr_next_last", lq[0], 1);
    end
    check("clr_next_done", mq.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
